rom_ddr_responder: RTL and testbench

Responder end of the toggle request/acknowledge ROM port. It serves 16-bit cartridge-ROM writes from the loader and 16-bit reads from the console core, translating each request into a single-beat access on the 64-bit DDRAM Avalon-style interface. A one-line (64-bit) read cache absorbs sequential fetches. It sits between the top-level ROM mux and the DDRAM ports, in the `clk_ram` domain.

---
 rtl/rom_ddr_responder_pkg.sv | 27 ++
 rtl/rom_ddr_responder_if.sv | 42 ++++
 rtl/rom_ddr_responder.sv | 161 ++++++++++++++++
 tb/tb_rom_ddr_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_ddr_responder_pkg.sv
// Shared types and helpers for the ROM-to-DDRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_ddr_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  // Every DDRAM access is a single 64-bit beat
  localparam logic [7:0] BURST_ONE = 8'd1;

  // Byte-enable pair for 16-bit word w of a 64-bit line
  function automatic logic [7:0] be_of(logic [1:0] w);
    return 8'b0000_0011 << {w, 1'b0};
  endfunction

  // Extract 16-bit word w of a 64-bit line (word 0 = bits 15:0)
  function automatic logic [15:0] word_of(logic [63:0] line, logic [1:0] w);
    return line[{w, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/rom_ddr_responder_if.sv
// DDRAM Avalon-style command/data bundle between the responder and memory.
// Latency: n/a (wires only).
// Backpressure: DDRAM_BUSY stalls an asserted RD/WE command.
interface rom_ddr_responder_if;

  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  // Command issuer (the responder)
  modport master (
    input  DDRAM_BUSY,
    input  DDRAM_DOUT,
    input  DDRAM_DOUT_READY,
    output DDRAM_BURSTCNT,
    output DDRAM_ADDR,
    output DDRAM_RD,
    output DDRAM_DIN,
    output DDRAM_BE,
    output DDRAM_WE
  );

  // Memory controller side
  modport slave (
    output DDRAM_BUSY,
    output DDRAM_DOUT,
    output DDRAM_DOUT_READY,
    input  DDRAM_BURSTCNT,
    input  DDRAM_ADDR,
    input  DDRAM_RD,
    input  DDRAM_DIN,
    input  DDRAM_BE,
    input  DDRAM_WE
  );

endinterface

// File: rtl/rom_ddr_responder.sv
// Toggle req/ack ROM port served from 64-bit DDRAM with a one-line read cache.
// Latency: cache hit 1 cycle; write >=2 cycles; read miss >=3 cycles.
// Backpressure: DDRAM_BUSY holds RD/WE and the command until accepted.
module rom_ddr_responder
  import rom_ddr_pkg::*;
#(
  parameter logic [28:0] BASE = 29'h0600000
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic [22:1] rdaddr,
  output logic [15:0] dout,
  input  logic        rd_req,
  output logic        rd_ack,
  rom_ddr_responder_if.master ddr
);

  state_t      state_q, state_d;
  logic        we_ack_q, we_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic [15:0] dout_q, dout_d;
  logic        rd_q, rd_d;
  logic        we_q, we_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] cache_dat_q, cache_dat_d;
  logic [19:0] cache_tag_q, cache_tag_d;
  logic        cache_vld_q, cache_vld_d;

  logic        wr_pend;
  logic        rd_pend;
  logic        rd_hit;
  logic        wr_hit;

  // Byte address bit 0 is meaningless for 16-bit writes
  logic        unused_wraddr_b0;
  assign unused_wraddr_b0 = wraddr[0];

  assign wr_pend = (we_req != we_ack_q);
  assign rd_pend = (rd_req != rd_ack_q);
  assign rd_hit  = cache_vld_q && (cache_tag_q == rdaddr[22:3]);
  // Cache only holds lines in the read window, so upper write bits must be zero
  assign wr_hit  = cache_vld_q && ({2'b00, cache_tag_q} == wraddr[24:3]);

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    state_d     = state_q;
    we_ack_d    = we_ack_q;
    rd_ack_d    = rd_ack_q;
    dout_d      = dout_q;
    rd_d        = rd_q;
    we_d        = we_q;
    addr_d      = addr_q;
    din_d       = din_q;
    be_d        = be_q;
    cache_dat_d = cache_dat_q;
    cache_tag_d = cache_tag_q;
    cache_vld_d = cache_vld_q;

    case (state_q)
      ST_IDLE: begin
        // Writes win so loader traffic cannot be starved by core fetches
        if (wr_pend) begin
          addr_d  = BASE | {7'd0, wraddr[24:3]};
          din_d   = {4{din}};
          be_d    = be_of(wraddr[2:1]);
          we_d    = 1'b1;
          state_d = ST_WR_ISSUE;
        end else if (rd_pend) begin
          if (rd_hit) begin
            dout_d   = word_of(cache_dat_q, rdaddr[2:1]);
            rd_ack_d = ~rd_ack_q;
          end else begin
            addr_d  = BASE | {9'd0, rdaddr[22:3]};
            rd_d    = 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_WR_ISSUE: begin
        if (!ddr.DDRAM_BUSY) begin
          we_d     = 1'b0;
          we_ack_d = ~we_ack_q;
          // Keep the cached line coherent with what memory now holds
          if (wr_hit) begin
            cache_dat_d[{wraddr[2:1], 4'b0000} +: 16] = din;
          end
          state_d = ST_IDLE;
        end
      end

      ST_RD_ISSUE: begin
        if (!ddr.DDRAM_BUSY) begin
          rd_d    = 1'b0;
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (ddr.DDRAM_DOUT_READY) begin
          cache_dat_d = ddr.DDRAM_DOUT;
          cache_tag_d = rdaddr[22:3];
          cache_vld_d = 1'b1;
          dout_d      = word_of(ddr.DDRAM_DOUT, rdaddr[2:1]);
          rd_ack_d    = ~rd_ack_q;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_ram) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      we_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      dout_q      <= 16'd0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= BASE;
      din_q       <= 64'd0;
      be_q        <= 8'd0;
      cache_dat_q <= 64'd0;
      cache_tag_q <= 20'd0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_ack_q    <= we_ack_d;
      rd_ack_q    <= rd_ack_d;
      dout_q      <= dout_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      be_q        <= be_d;
      cache_dat_q <= cache_dat_d;
      cache_tag_q <= cache_tag_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  assign we_ack              = we_ack_q;
  assign rd_ack              = rd_ack_q;
  assign dout                = dout_q;
  assign ddr.DDRAM_BURSTCNT  = BURST_ONE;
  assign ddr.DDRAM_ADDR      = addr_q;
  assign ddr.DDRAM_RD        = rd_q;
  assign ddr.DDRAM_DIN       = din_q;
  assign ddr.DDRAM_BE        = be_q;
  assign ddr.DDRAM_WE        = we_q;

endmodule

// File: tb/tb_rom_ddr_responder.sv
// Directed bench for rom_ddr_responder: reset, write, miss/hit reads,
// write-through into the cached line, simultaneous requests, reset mid-read.
module tb_rom_ddr_responder;

  logic        clk_ram;
  logic        reset_n;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic [22:1] rdaddr;
  logic [15:0] dout;
  logic        rd_req;
  logic        rd_ack;

  int n_cmp;
  int n_err;
  int wr_acc;
  int rd_acc;

  rom_ddr_responder_if ddr ();

  rom_ddr_responder #(.BASE(29'h0600000)) dut (
    .clk_ram (clk_ram),
    .reset_n (reset_n),
    .wraddr  (wraddr),
    .din     (din),
    .we_req  (we_req),
    .we_ack  (we_ack),
    .rdaddr  (rdaddr),
    .dout    (dout),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .ddr     (ddr)
  );

  initial begin
    clk_ram = 1'b0;
    forever #5 clk_ram = ~clk_ram;
  end

  // Count commands accepted by memory (command high, not busy, at an edge)
  always @(posedge clk_ram) begin
    if (reset_n && ddr.DDRAM_WE && !ddr.DDRAM_BUSY) wr_acc++;
    if (reset_n && ddr.DDRAM_RD && !ddr.DDRAM_BUSY) rd_acc++;
  end

  task automatic step();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; wr_acc = 0; rd_acc = 0;
    reset_n = 1'b0;
    wraddr = '0; din = '0; we_req = 1'b0;
    rdaddr = '0; rd_req = 1'b0;
    ddr.DDRAM_BUSY = 1'b0;
    ddr.DDRAM_DOUT = '0;
    ddr.DDRAM_DOUT_READY = 1'b0;

    // Reset held for three cycles
    step(); step(); step();
    check("rst_we_ack", 64'(we_ack), 64'd0);
    check("rst_rd_ack", 64'(rd_ack), 64'd0);
    check("rst_dout",   64'(dout), 64'd0);
    check("rst_rd",     64'(ddr.DDRAM_RD), 64'd0);
    check("rst_we",     64'(ddr.DDRAM_WE), 64'd0);
    check("rst_addr",   64'(ddr.DDRAM_ADDR), 64'h0600000);
    check("rst_din",    ddr.DDRAM_DIN, 64'd0);
    check("rst_be",     64'(ddr.DDRAM_BE), 64'd0);
    check("rst_burst",  64'(ddr.DDRAM_BURSTCNT), 64'd1);
    reset_n = 1'b1;
    step();

    // Write A55A to byte 6 -> word 3 of line 0
    wraddr = 25'h000006; din = 16'hA55A; we_req = 1'b1;
    step();
    check("wr1_we",    64'(ddr.DDRAM_WE), 64'd1);
    check("wr1_addr",  64'(ddr.DDRAM_ADDR), 64'h0600000);
    check("wr1_be",    64'(ddr.DDRAM_BE), 64'hC0);
    check("wr1_din",   ddr.DDRAM_DIN, 64'hA55A_A55A_A55A_A55A);
    check("wr1_ack_pre", 64'(we_ack), 64'd0);
    step();
    check("wr1_we_drop", 64'(ddr.DDRAM_WE), 64'd0);
    check("wr1_ack",   64'(we_ack), 64'd1);
    check("wr1_count", 64'(wr_acc), 64'd1);

    // Read miss at word 0
    rdaddr = 22'h000000; rd_req = 1'b1;
    step();
    check("rm_rd",   64'(ddr.DDRAM_RD), 64'd1);
    check("rm_addr", 64'(ddr.DDRAM_ADDR), 64'h0600000);
    step();
    check("rm_rd_drop", 64'(ddr.DDRAM_RD), 64'd0);
    step(); step(); step();
    check("rm_ack_wait", 64'(rd_ack), 64'd0);
    ddr.DDRAM_DOUT = 64'h4444_3333_2222_1111;
    ddr.DDRAM_DOUT_READY = 1'b1;
    step();
    ddr.DDRAM_DOUT_READY = 1'b0;
    check("rm_ack",  64'(rd_ack), 64'd1);
    check("rm_dout", 64'(dout), 64'h1111);

    // Hit on word 2 of the same line
    rdaddr = 22'h000002; rd_req = 1'b0;
    step();
    check("rh_ack",  64'(rd_ack), 64'd0);
    check("rh_dout", 64'(dout), 64'h3333);
    check("rh_no_rd", 64'(ddr.DDRAM_RD), 64'd0);
    check("rh_count", 64'(rd_acc), 64'd1);

    // Write BEEF into word 1 of the cached line, then read it back from cache
    wraddr = 25'h000002; din = 16'hBEEF; we_req = 1'b0;
    step();
    check("wr2_be", 64'(ddr.DDRAM_BE), 64'h0C);
    step();
    check("wr2_ack", 64'(we_ack), 64'd0);
    rdaddr = 22'h000001; rd_req = 1'b1;
    step();
    check("wh_ack",  64'(rd_ack), 64'd1);
    check("wh_dout", 64'(dout), 64'hBEEF);
    check("wh_no_rd", 64'(ddr.DDRAM_RD), 64'd0);

    // Simultaneous requests with memory busy: write first, read afterwards
    ddr.DDRAM_BUSY = 1'b1;
    wraddr = 25'h000010; din = 16'h1234; we_req = 1'b1;
    rdaddr = 22'h000100; rd_req = 1'b0;
    step();
    check("sim_we",   64'(ddr.DDRAM_WE), 64'd1);
    check("sim_rd0",  64'(ddr.DDRAM_RD), 64'd0);
    check("sim_waddr", 64'(ddr.DDRAM_ADDR), 64'h0600002);
    check("sim_be",   64'(ddr.DDRAM_BE), 64'h03);
    step(); step(); step();
    check("sim_we_held", 64'(ddr.DDRAM_WE), 64'd1);
    check("sim_wack_held", 64'(we_ack), 64'd0);
    ddr.DDRAM_BUSY = 1'b0;
    step();
    check("sim_wack", 64'(we_ack), 64'd1);
    check("sim_we_drop", 64'(ddr.DDRAM_WE), 64'd0);
    step();
    check("sim_rd",    64'(ddr.DDRAM_RD), 64'd1);
    check("sim_raddr", 64'(ddr.DDRAM_ADDR), 64'h0600040);
    step();
    check("sim_rd_drop", 64'(ddr.DDRAM_RD), 64'd0);
    ddr.DDRAM_DOUT = 64'h8888_7777_6666_5555;
    ddr.DDRAM_DOUT_READY = 1'b1;
    step();
    ddr.DDRAM_DOUT_READY = 1'b0;
    check("sim_rack",  64'(rd_ack), 64'd0);
    check("sim_dout",  64'(dout), 64'h5555);
    step();
    check("sim_wr_count", 64'(wr_acc), 64'd3);
    check("sim_rd_count", 64'(rd_acc), 64'd2);
    check("sim_wack_once", 64'(we_ack), 64'd1);

    // Miss, then reset while waiting for data; late data must be ignored
    rdaddr = 22'h000400; rd_req = 1'b1;
    step();
    check("rr_rd", 64'(ddr.DDRAM_RD), 64'd1);
    step();
    reset_n = 1'b0; rd_req = 1'b0; we_req = 1'b0;
    step();
    check("rr_rd_drop", 64'(ddr.DDRAM_RD), 64'd0);
    check("rr_rack", 64'(rd_ack), 64'd0);
    check("rr_wack", 64'(we_ack), 64'd0);
    check("rr_dout", 64'(dout), 64'd0);
    reset_n = 1'b1;
    ddr.DDRAM_DOUT = 64'hDEAD_BEEF_CAFE_F00D;
    ddr.DDRAM_DOUT_READY = 1'b1;
    step();
    ddr.DDRAM_DOUT_READY = 1'b0;
    check("rr_late_rack", 64'(rd_ack), 64'd0);
    check("rr_late_dout", 64'(dout), 64'd0);
    // Line cached before reset must now miss
    rdaddr = 22'h000100; rd_req = 1'b1;
    step();
    check("rr_inval_rd", 64'(ddr.DDRAM_RD), 64'd1);
    check("rr_inval_rack", 64'(rd_ack), 64'd0);
    step();
    ddr.DDRAM_DOUT = 64'h0000_0000_0000_7A7A;
    ddr.DDRAM_DOUT_READY = 1'b1;
    step();
    ddr.DDRAM_DOUT_READY = 1'b0;
    check("rr_refill_rack", 64'(rd_ack), 64'd1);
    check("rr_refill_dout", 64'(dout), 64'h7A7A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
